// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt controller for the OTTER RISC-V core.
// Synchronises external interrupt lines, turns rising edges into pending
// events, applies per-source mask and global MIE, and runs the intr/int_taken
// handshake toward the control unit. No nesting: once a request is taken,
// further requests are held off until mret.
//
// Ports:
//   clk         system clock, all state on rising edge
//   RST         synchronous active-high reset
//   irq_in      asynchronous external interrupt lines (level, active-high)
//   irq_mask    per-source enable, 1 = enabled
//   mie         global interrupt enable (mstatus.MIE)
//   int_taken   control unit is in its INTERRUPT state this cycle
//   mret        one-cycle pulse, handler returned
//   intr        interrupt request to the control unit
//   int_id      registered ID of the source being serviced
//   int_pending current pending bits
//   in_service  high while a handler is active
module intr_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               mie,
    input  logic               int_taken,
    input  logic               mret,
    output logic               intr,
    output logic [ID_W-1:0]    int_id,
    output logic [NUM_SRC-1:0] int_pending,
    output logic               in_service
);

    // One-hot style encoding so that the two unused codes exist and can be
    // steered back to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'b01,
        SERVICE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [ID_W-1:0]    id_q, id_d;

    logic [NUM_SRC-1:0] edge_w;
    logic [NUM_SRC-1:0] req_w;
    logic [NUM_SRC-1:0] win_oh;
    logic [ID_W-1:0]    win_id;
    logic               win_found;
    logic [NUM_SRC-1:0] clr_w;

    // s1/s2 are the synchroniser; s3 holds the previous synchronised level.
    assign edge_w = s2_q & ~s3_q;
    assign req_w  = pend_q & irq_mask;

    // Fixed priority: lowest index wins.
    always_comb begin
        win_oh    = '0;
        win_id    = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!win_found && req_w[i]) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
                win_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        clr_w      = '0;
        intr       = 1'b0;
        in_service = 1'b0;
        case (state_q)
            IDLE: begin
                intr = mie & win_found;
                if (int_taken && intr) begin
                    id_d    = win_id;
                    clr_w   = win_oh;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                in_service = 1'b1;
                if (mret) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new edge on the source being cleared keeps the bit set.
    assign pend_d = (pend_q & ~clr_w) | edge_w;

    always_ff @(posedge clk) begin
        if (RST) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pend_q  <= '0;
            id_q    <= '0;
            state_q <= IDLE;
        end else begin
            s1_q    <= irq_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pend_q  <= pend_d;
            id_q    <= id_d;
            state_q <= state_d;
        end
    end

    assign int_id      = id_q;
    assign int_pending = pend_q;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       RST;
    logic [3:0] irq_in;
    logic [3:0] irq_mask;
    logic       mie;
    logic       int_taken;
    logic       mret;
    logic       intr;
    logic [1:0] int_id;
    logic [3:0] int_pending;
    logic       in_service;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intr_ctrl #(.NUM_SRC(4), .ID_W(2)) dut (
        .clk        (clk),
        .RST        (RST),
        .irq_in     (irq_in),
        .irq_mask   (irq_mask),
        .mie        (mie),
        .int_taken  (int_taken),
        .mret       (mret),
        .intr       (intr),
        .int_id     (int_id),
        .int_pending(int_pending),
        .in_service (in_service)
    );

    // Reference model: history of irq_in as sampled at each clock edge,
    // newest first. A source raises an event at edge k when it was sampled
    // high at edge k-2 and low at edge k-3.
    logic [3:0] samples[$];
    logic [3:0] m_pend;
    logic       m_serving;
    int         m_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_edge();
        logic [3:0] ev;
        int         w;
        if (RST) begin
            m_pend    = '0;
            m_serving = 1'b0;
            m_id      = 0;
            samples   = '{4'h0, 4'h0, 4'h0};
        end else begin
            ev = samples[1] & ~samples[2];
            samples.push_front(irq_in);
            void'(samples.pop_back());
            w = lowest(m_pend & irq_mask);
            if (m_serving) begin
                if (mret) m_serving = 1'b0;
            end else if (int_taken && mie && w >= 0) begin
                m_id      = w;
                m_pend[w] = 1'b0;
                m_serving = 1'b1;
            end
            m_pend = m_pend | ev;
        end
    endtask

    task automatic compare_all();
        logic exp_intr;
        exp_intr = !m_serving && mie && ((m_pend & irq_mask) != 4'h0);
        check("intr", intr, exp_intr);
        check("int_id", int_id, m_id);
        check("int_pending", int_pending, m_pend);
        check("in_service", in_service, m_serving);
    endtask

    // Inputs are already driven; take one edge, update model, check #1 after.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        int_taken = 1'b0;
        mret      = 1'b0;
    endtask

    initial begin
        samples   = '{4'h0, 4'h0, 4'h0};
        m_pend    = '0;
        m_serving = 1'b0;
        m_id      = 0;
        RST = 1'b1; irq_in = '0; irq_mask = 4'hF; mie = 1'b1;
        int_taken = 1'b0; mret = 1'b0;
        #1;
        step(); step();
        RST = 1'b0;
        check("reset_intr", intr, 0);
        check("reset_pending", int_pending, 0);
        check("reset_in_service", in_service, 0);

        // Basic request on source 2
        irq_in = 4'b0100;
        step(); step(); step();
        check("basic_pending", int_pending, 4'b0100);
        check("basic_intr", intr, 1);
        irq_in = '0;
        int_taken = 1'b1;
        step();
        check("basic_id", int_id, 2);
        check("basic_svc", in_service, 1);
        check("basic_pend_clr", int_pending, 0);
        mret = 1'b1;
        step();
        check("basic_mret_svc", in_service, 0);
        check("basic_mret_intr", intr, 0);

        // Priority: sources 3 and 1 together
        irq_in = 4'b1010;
        step(); step(); step();
        irq_in = '0;
        check("prio_pending", int_pending, 4'b1010);
        int_taken = 1'b1;
        step();
        check("prio_id1", int_id, 1);
        check("prio_pend1", int_pending, 4'b1000);
        check("prio_svc_intr", intr, 0);
        mret = 1'b1;
        step();
        check("prio_reassert", intr, 1);
        int_taken = 1'b1;
        step();
        check("prio_id3", int_id, 3);
        mret = 1'b1;
        step();

        // Masking and global enable
        irq_mask = 4'b1110;
        irq_in = 4'b0001;
        step(); step(); step();
        irq_in = '0;
        check("mask_pending", int_pending, 4'b0001);
        check("mask_intr", intr, 0);
        irq_mask = 4'b1111;
        #1;
        check("unmask_intr", intr, 1);
        mie = 1'b0;
        #1;
        check("mie_off_intr", intr, 0);
        check("mie_off_pending", int_pending, 4'b0001);
        step();
        // Spurious take in IDLE with intr low
        int_taken = 1'b1;
        step();
        check("spurious_id", int_id, 3);
        check("spurious_svc", in_service, 0);
        mie = 1'b1;
        int_taken = 1'b1;
        step();
        check("take0_id", int_id, 0);
        mret = 1'b1;
        step();

        // Simultaneous set/clear on source 2
        irq_in = 4'b0100;
        step(); step(); step();
        irq_in = '0;
        step();
        irq_in = 4'b0100;
        step();   // sampled high; event arrives two edges later
        step();
        int_taken = 1'b1;
        step();
        check("setclr_id", int_id, 2);
        check("setclr_pending", int_pending, 4'b0100);
        irq_in = '0;
        mret = 1'b1;
        step();
        irq_in = 4'b0110;
        step(); step(); step();
        int_taken = 1'b1;
        step();   // takes source 1 (2 still pending from before)

        // Reset mid-service with irq_in[1] held high through reset
        irq_in = 4'b0010;
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("rst_pending", int_pending, 0);
        check("rst_svc", in_service, 0);
        check("rst_id", int_id, 0);
        step(); step();
        check("held_pending_early", int_pending, 0);
        step();
        check("held_pending", int_pending, 4'b0010);
        irq_mask = 4'b0000;
        for (int i = 0; i < 5; i++) step();
        check("held_no_more", int_pending, 4'b0010);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            RST       = ($urandom_range(0, 79) == 0);
            irq_in    = 4'($urandom);
            irq_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            mie       = ($urandom_range(0, 7) != 0);
            int_taken = ($urandom_range(0, 3) == 0);
            mret      = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
